alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle operation sequencer for the shared 16-bit ALU. It implements the operations the ALU lacks (multiply, multi-bit barrel shifts) by driving the ALU through repeated single-cycle steps: add, lsl, lsr, asr. It sits beside the execute stage and takes ownership of the ALU input port while busy. An external mux selects its drives over the pipeline's whenever `alu_sel` is high.

## Interface

Parameters:
- BITS, 16, datapath width; must match the ALU.
- CNT_W, $clog2(BITS), shift-count width.

Ports:
- CLK  in  1  clock.
- RSTb  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 0 MUL (low BITS of a*b, unsigned), 1 BSL, 2 BSR (logical), 3 BSRA (arithmetic).
- a  in  BITS  multiplicand, or shift source.
- b  in  BITS  multiplier, or shift count in b[CNT_W-1:0] (upper bits ignored).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- result  out  BITS  held from DONE until the next accepted start.
- alu_sel  out  1  equals busy; steers the ALU input mux.
- alu_A  out  BITS  ALU A operand.
- alu_B  out  BITS  ALU B operand.
- alu_op  out  5  ALU opcode.
- alu_exec  out  1  ALU execute strobe.
- alu_out  in  BITS  ALU registered result.

## Operation

- ALU contract:
  - Asserting alu_exec with alu_op/A/B in cycle t makes alu_out valid in cycle t+1.
  - Flags update at the same edge.
  - Opcodes used: 1 add, 16 asr, 17 lsr, 18 lsl, 29 store flags (alu_out = {0,S,C,Z}), 30 restore flags from B[2:0].
- Each ALU step takes two cycles:
  - ISSUE: alu_exec=1.
  - WB: alu_exec=0; the target register captures alu_out.
- State registers: acc, mcand, mplier, cnt, saved_flags[2:0].
- States: IDLE, SAVE, SAVE_WB, ADD, ADD_WB, SHF, SHF_WB, RESTORE, DONE.
- IDLE, start=1: load mcand=a, mplier=b, acc=0 (shifts: acc=a, cnt=b[CNT_W-1:0]). Go to SAVE (macro on) or the first work state.
- MUL loop, while mplier≠0:
  - If mplier[0]: ADD (A=acc, B=mcand), ADD_WB acc←alu_out.
  - Then SHF (op 18, B=mcand), SHF_WB mcand←alu_out, mplier←mplier>>1.
  - At most BITS iterations. mplier=0 at entry means no steps, result 0.
- Shift loop, while cnt≠0: SHF (op 18/17/16, B=acc), SHF_WB acc←alu_out, cnt←cnt-1. cnt=0 gives result=a.
- Loop exit goes to RESTORE (macro on) or DONE.
- DONE: result←acc, done=1, then IDLE.
- Add carry-out is discarded. Product bits above BITS are lost.
- start while busy is ignored; no queueing.
- Idle drives: alu_exec=0, alu_op=0, alu_A=alu_B=0.

## Timing

- Reset values: busy=0, done=0, result=0, alu_sel=0, alu_exec=0, alu_op=0, alu_A=0, alu_B=0; all internal registers 0; state IDLE.
- Reset mid-operation aborts immediately. No flag restore is performed; ALU flags are left as they were.
- Start accepted in cycle 0; done lands in cycle L:
  - Shift by n: L = 1 + 2n, plus 3 with macro.
  - MUL, h = index of b's highest set bit, p = popcount(b): L = 1 + 2(h+1) + 2p, plus 3 with macro. b=0 gives L=1 (+3).
- Macro adds SAVE and SAVE_WB (2 cycles) before work, and RESTORE (1 cycle, exec=1, B=saved_flags) before DONE.
- A new start is accepted no earlier than the cycle after DONE.

## Configuration

- ALU_SEQ_FLAG_PRESERVE_EN defined: C/Z/S are saved before and restored after the sequence. Flags are identical before start and after done.
- ALU_SEQ_FLAG_PRESERVE_EN undefined: SAVE/RESTORE are omitted. Flags are left as the last ALU step set them (no step means unchanged).

## Structure

- Shared package alu_pkg holds:
  - ALU opcode constants (ADD, ASR, LSR, LSL, STF, RSTF).
  - The sequencer op enum (MUL, BSL, BSR, BSRA).
  - The state enum.
- One sub-module, alu_port_mux: selects pipeline vs sequencer A/B/op/exec on alu_sel. It is instantiated at core level, not inside alu_seq.

## Test plan

- MUL a=3, b=5, macro off -> done at cycle 11, result 15. Two ADD steps, three SHF steps.
- MUL a=16'hFFFF, b=16'h0002 -> result 16'hFFFE; upper product bits discarded.
- BSRA a=16'h8010, n=4 -> result 16'hF801, done at cycle 9 (12 with macro). BSR on the same input -> 16'h0801.
- Macro on, flags C=1, Z=0, S=1 preset; BSL a=1, n=15 -> result 16'h8000, flags still C=1, Z=0, S=1 after done.
- Start pulsed every cycle during a MUL -> exactly one done. A second start in the cycle after DONE is accepted.
- RSTb low mid-MUL -> next cycle busy=0, result=0, alu_exec=0. A following BSL a=1, n=1 -> result 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer operations and sequencer states.
package alu_pkg;

    localparam int unsigned OP_W     = 5;
    localparam int unsigned SEQ_OP_W = 2;
    localparam int unsigned FLAG_W   = 3;

    localparam logic [OP_W-1:0] ALU_NOP  = 5'd0;
    localparam logic [OP_W-1:0] ALU_ADD  = 5'd1;
    localparam logic [OP_W-1:0] ALU_ASR  = 5'd16;
    localparam logic [OP_W-1:0] ALU_LSR  = 5'd17;
    localparam logic [OP_W-1:0] ALU_LSL  = 5'd18;
    localparam logic [OP_W-1:0] ALU_STF  = 5'd29;
    localparam logic [OP_W-1:0] ALU_RSTF = 5'd30;

    typedef enum logic [SEQ_OP_W-1:0] {
        SEQ_MUL  = 2'd0,
        SEQ_BSL  = 2'd1,
        SEQ_BSR  = 2'd2,
        SEQ_BSRA = 2'd3
    } seq_op_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SAVE    = 4'd1,
        ST_SAVE_WB = 4'd2,
        ST_ADD     = 4'd3,
        ST_ADD_WB  = 4'd4,
        ST_SHF     = 4'd5,
        ST_SHF_WB  = 4'd6,
        ST_RESTORE = 4'd7,
        ST_DONE    = 4'd8
    } seq_state_e;

    // Single-bit ALU shift used for one step of each sequencer operation.
    function automatic logic [OP_W-1:0] shift_opcode(input seq_op_e sop);
        case (sop)
            SEQ_BSR:  return ALU_LSR;
            SEQ_BSRA: return ALU_ASR;
            default:  return ALU_LSL;
        endcase
    endfunction

endpackage

// File: rtl/alu_port_mux.sv
// ALU input port mux: the sequencer owns the ALU while i_sel is high.
module alu_port_mux
    import alu_pkg::*;
#(
    parameter int unsigned BITS = 16
) (
    input  logic            i_sel,
    input  logic [BITS-1:0] i_pipe_a,
    input  logic [BITS-1:0] i_pipe_b,
    input  logic [OP_W-1:0] i_pipe_op,
    input  logic            i_pipe_exec,
    input  logic [BITS-1:0] i_seq_a,
    input  logic [BITS-1:0] i_seq_b,
    input  logic [OP_W-1:0] i_seq_op,
    input  logic            i_seq_exec,
    output logic [BITS-1:0] o_alu_a_c,
    output logic [BITS-1:0] o_alu_b_c,
    output logic [OP_W-1:0] o_alu_op_c,
    output logic            o_alu_exec_c
);

    always_comb begin
        o_alu_a_c    = i_pipe_a;
        o_alu_b_c    = i_pipe_b;
        o_alu_op_c   = i_pipe_op;
        o_alu_exec_c = i_pipe_exec;
        if (i_sel) begin
            o_alu_a_c    = i_seq_a;
            o_alu_b_c    = i_seq_b;
            o_alu_op_c   = i_seq_op;
            o_alu_exec_c = i_seq_exec;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle sequencer driving the shared ALU for MUL and barrel shifts.
// ALU_SEQ_FLAG_PRESERVE_EN wraps each sequence with ALU flag save/restore steps.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned BITS  = 16,
    parameter int unsigned CNT_W = $clog2(BITS)
) (
    input  logic                CLK,
    input  logic                RSTb,
    input  logic                start,
    input  logic [SEQ_OP_W-1:0] op,
    input  logic [BITS-1:0]     a,
    input  logic [BITS-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [BITS-1:0]     result,
    output logic                alu_sel,
    output logic [BITS-1:0]     alu_A,
    output logic [BITS-1:0]     alu_B,
    output logic [OP_W-1:0]     alu_op,
    output logic                alu_exec,
    input  logic [BITS-1:0]     alu_out
);

`ifdef ALU_SEQ_FLAG_PRESERVE_EN
    localparam seq_state_e ST_EXIT = ST_RESTORE;
`else
    localparam seq_state_e ST_EXIT = ST_DONE;
`endif

    seq_state_e        r_state;
    seq_op_e           r_op;
    logic [BITS-1:0]   r_acc;
    logic [BITS-1:0]   r_mcand;
    logic [BITS-1:0]   r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic [FLAG_W-1:0] r_saved_flags;
    logic              r_busy;
    logic              r_done;
    logic [BITS-1:0]   r_result;
    logic [BITS-1:0]   r_alu_a;
    logic [BITS-1:0]   r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_alu_exec;

    seq_state_e        w_state_nxt;
    seq_op_e           w_op_nxt;
    logic [BITS-1:0]   w_acc_nxt;
    logic [BITS-1:0]   w_mcand_nxt;
    logic [BITS-1:0]   w_mplier_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [FLAG_W-1:0] w_flags_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [BITS-1:0]   w_result_nxt;
    logic [BITS-1:0]   w_alu_a_nxt;
    logic [BITS-1:0]   w_alu_b_nxt;
    logic [OP_W-1:0]   w_alu_op_nxt;
    logic              w_alu_exec_nxt;

    // Next work step given the loop variables: add, shift, or leave the loop.
    function automatic seq_state_e work_state(input seq_op_e sop,
                                              input logic [BITS-1:0] mpl,
                                              input logic [CNT_W-1:0] cnt);
        if (sop == SEQ_MUL) begin
            if (mpl == '0) return ST_EXIT;
            return mpl[0] ? ST_ADD : ST_SHF;
        end
        return (cnt == '0) ? ST_EXIT : ST_SHF;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_state       <= ST_IDLE;
            r_op          <= SEQ_MUL;
            r_acc         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_cnt         <= '0;
            r_saved_flags <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_op      <= ALU_NOP;
            r_alu_exec    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_op          <= w_op_nxt;
            r_acc         <= w_acc_nxt;
            r_mcand       <= w_mcand_nxt;
            r_mplier      <= w_mplier_nxt;
            r_cnt         <= w_cnt_nxt;
            r_saved_flags <= w_flags_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_result      <= w_result_nxt;
            r_alu_a       <= w_alu_a_nxt;
            r_alu_b       <= w_alu_b_nxt;
            r_alu_op      <= w_alu_op_nxt;
            r_alu_exec    <= w_alu_exec_nxt;
        end
    end

    // Next state and loop variables; write-back states capture the ALU result.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_cnt_nxt    = r_cnt;
        w_flags_nxt  = r_saved_flags;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op_nxt     = seq_op_e'(op);
                    w_mcand_nxt  = a;
                    w_mplier_nxt = b;
                    w_cnt_nxt    = b[CNT_W-1:0];
                    w_acc_nxt    = (seq_op_e'(op) == SEQ_MUL) ? '0 : a;
`ifdef ALU_SEQ_FLAG_PRESERVE_EN
                    w_state_nxt  = ST_SAVE;
`else
                    w_state_nxt  = work_state(seq_op_e'(op), b, b[CNT_W-1:0]);
`endif
                end
            end
            ST_SAVE: w_state_nxt = ST_SAVE_WB;
            ST_SAVE_WB: begin
                w_flags_nxt = alu_out[FLAG_W-1:0];
                w_state_nxt = work_state(r_op, r_mplier, r_cnt);
            end
            ST_ADD: w_state_nxt = ST_ADD_WB;
            ST_ADD_WB: begin
                w_acc_nxt   = alu_out;
                w_state_nxt = ST_SHF;
            end
            ST_SHF: w_state_nxt = ST_SHF_WB;
            ST_SHF_WB: begin
                if (r_op == SEQ_MUL) begin
                    w_mcand_nxt  = alu_out;
                    w_mplier_nxt = r_mplier >> 1;
                end else begin
                    w_acc_nxt = alu_out;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
                w_state_nxt = work_state(r_op, w_mplier_nxt, w_cnt_nxt);
            end
            ST_RESTORE: w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so that every port is a flop.
    always_comb begin
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
        w_done_nxt     = (w_state_nxt == ST_DONE);
        w_result_nxt   = r_result;
        w_alu_a_nxt    = '0;
        w_alu_b_nxt    = '0;
        w_alu_op_nxt   = ALU_NOP;
        w_alu_exec_nxt = 1'b0;
        if (w_state_nxt == ST_DONE) begin
            w_result_nxt = w_acc_nxt;
        end
        case (w_state_nxt)
            ST_SAVE: begin
                w_alu_op_nxt   = ALU_STF;
                w_alu_exec_nxt = 1'b1;
            end
            ST_ADD: begin
                w_alu_a_nxt    = w_acc_nxt;
                w_alu_b_nxt    = w_mcand_nxt;
                w_alu_op_nxt   = ALU_ADD;
                w_alu_exec_nxt = 1'b1;
            end
            ST_SHF: begin
                w_alu_b_nxt    = (w_op_nxt == SEQ_MUL) ? w_mcand_nxt : w_acc_nxt;
                w_alu_op_nxt   = shift_opcode(w_op_nxt);
                w_alu_exec_nxt = 1'b1;
            end
            ST_RESTORE: begin
                w_alu_b_nxt    = BITS'(w_flags_nxt);
                w_alu_op_nxt   = ALU_RSTF;
                w_alu_exec_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = r_busy;
    assign alu_sel  = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign alu_A    = r_alu_a;
    assign alu_B    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign alu_exec = r_alu_exec;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a behavioural ALU behind alu_port_mux, plus a reference
// model of result, latency, ALU step count and flag behaviour.
module tb_alu_seq;

`ifdef ALU_SEQ_FLAG_PRESERVE_EN
    localparam int EXTRA_CYC   = 3;
    localparam int EXTRA_STEPS = 2;
`else
    localparam int EXTRA_CYC   = 0;
    localparam int EXTRA_STEPS = 0;
`endif

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done, alu_sel, alu_exec;
    logic [15:0] result, alu_A, alu_B;
    logic [4:0]  alu_op;
    logic [15:0] alu_out = 16'd0;
    logic [2:0]  alu_flags = 3'd0;

    logic [15:0] pipe_a = 16'd0, pipe_b = 16'd0;
    logic [4:0]  pipe_op = 5'd0;
    logic        pipe_exec = 1'b0;
    logic [15:0] x_a, x_b;
    logic [4:0]  x_op;
    logic        x_exec;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    alu_seq dut (
        .CLK(CLK), .RSTb(RSTb), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .alu_sel(alu_sel),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_exec(alu_exec),
        .alu_out(alu_out)
    );

    alu_port_mux u_mux (
        .i_sel(alu_sel),
        .i_pipe_a(pipe_a), .i_pipe_b(pipe_b), .i_pipe_op(pipe_op), .i_pipe_exec(pipe_exec),
        .i_seq_a(alu_A), .i_seq_b(alu_B), .i_seq_op(alu_op), .i_seq_exec(alu_exec),
        .o_alu_a_c(x_a), .o_alu_b_c(x_b), .o_alu_op_c(x_op), .o_alu_exec_c(x_exec)
    );

    // Behavioural ALU: flags are {S,C,Z}.
    logic [16:0] alu_sum;
    logic [15:0] alu_res;
    always @(posedge CLK) begin
        if (x_exec) begin
            case (x_op)
                5'd1: begin
                    alu_sum = {1'b0, x_a} + {1'b0, x_b};
                    alu_out   <= alu_sum[15:0];
                    alu_flags <= {alu_sum[15], alu_sum[16], alu_sum[15:0] == 16'd0};
                end
                5'd16, 5'd17: begin
                    alu_res = {(x_op == 5'd16) ? x_b[15] : 1'b0, x_b[15:1]};
                    alu_out   <= alu_res;
                    alu_flags <= {alu_res[15], x_b[0], alu_res == 16'd0};
                end
                5'd18: begin
                    alu_res = {x_b[14:0], 1'b0};
                    alu_out   <= alu_res;
                    alu_flags <= {alu_res[15], x_b[15], alu_res == 16'd0};
                end
                5'd29: alu_out <= {13'd0, alu_flags};
                5'd30: alu_flags <= x_b[2:0];
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [15:0] model_result(input logic [1:0] o, input logic [15:0] x,
                                                 input logic [15:0] y);
        logic [31:0] prod;
        logic [15:0] r;
        int n;
        n = int'(y[3:0]);
        prod = 32'(x) * 32'(y);
        case (o)
            2'd0:    r = prod[15:0];
            2'd1:    r = x << n;
            2'd2:    r = x >> n;
            default: r = 16'($signed(x) >>> n);
        endcase
        return r;
    endfunction

    function automatic int top_bit(input logic [15:0] y);
        int h = -1;
        for (int i = 0; i < 16; i++) if (y[i]) h = i;
        return h;
    endfunction

    function automatic int model_latency(input logic [1:0] o, input logic [15:0] y);
        if (o != 2'd0) return 1 + 2 * int'(y[3:0]) + EXTRA_CYC;
        return 1 + 2 * (top_bit(y) + 1) + 2 * $countones(y) + EXTRA_CYC;
    endfunction

    function automatic int model_steps(input logic [1:0] o, input logic [15:0] y);
        if (o != 2'd0) return int'(y[3:0]) + EXTRA_STEPS;
        return top_bit(y) + 1 + $countones(y) + EXTRA_STEPS;
    endfunction

    // Reference model: busy window, done cycle and held result.
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [15:0] m_result = 16'd0, m_pend = 16'd0;
    logic [2:0]  m_flags0 = 3'd0;
    int          m_cnt = 0, m_exec_exp = 0, m_exec_base = 0;
    int          exec_total = 0;
    logic        chk_en = 1'b0;

    always @(posedge CLK) begin
        m_done = 1'b0;
        if (!RSTb) begin
            m_busy   = 1'b0;
            m_result = 16'd0;
            m_cnt    = 0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy = 1'b0;
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done   = 1'b1;
                    m_result = m_pend;
                end
            end
        end else if (start) begin
            m_pend      = model_result(op, a, b);
            m_cnt       = model_latency(op, b) - 1;
            m_exec_exp  = model_steps(op, b);
            m_exec_base = exec_total;
            m_flags0    = alu_flags;
            m_busy      = 1'b1;
            if (m_cnt == 0) begin
                m_done   = 1'b1;
                m_result = m_pend;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("alu_sel", 32'(alu_sel), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("result", 32'(result), 32'(m_result));
            if (!m_busy) begin
                chk("idle_exec", 32'(alu_exec), 32'd0);
                chk("idle_op", 32'(alu_op), 32'd0);
                chk("idle_A", 32'(alu_A), 32'd0);
                chk("idle_B", 32'(alu_B), 32'd0);
            end
            if (m_busy && alu_exec) exec_total++;
            if (m_done) begin
                chk("exec_steps", 32'(exec_total - m_exec_base), 32'(m_exec_exp));
`ifdef ALU_SEQ_FLAG_PRESERVE_EN
                chk("flags_preserved", 32'(alu_flags), 32'(m_flags0));
`endif
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 300) begin
            @(negedge CLK);
            k++;
        end
        chk({nm, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb,
                          input logic [15:0] exp_r, input int exp_l, input string nm);
        int k;
        wait_idle();
        @(negedge CLK);
        op = o; a = aa; b = bb; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        k = 1;
        while (!done && k < 300) begin
            @(negedge CLK);
            k++;
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_latency"}, 32'(k), 32'(exp_l));
        chk({nm, "_result"}, 32'(result), 32'(exp_r));
    endtask

    initial begin
        int ndone;
        RSTb = 1'b0; start = 1'b0; op = 2'd0; a = 16'd0; b = 16'd0;
        @(posedge CLK);
        chk_en = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_exec", 32'(alu_exec), 32'd0);
        chk("rst_op", 32'(alu_op), 32'd0);
        RSTb = 1'b1;
        @(negedge CLK);

        run_op(2'd0, 16'd3, 16'd5, 16'd15, 11 + EXTRA_CYC, "mul_3x5");
        run_op(2'd0, 16'hFFFF, 16'h0002, 16'hFFFE, 7 + EXTRA_CYC, "mul_trunc");
        run_op(2'd0, 16'h1234, 16'h0000, 16'h0000, 1 + EXTRA_CYC, "mul_by0");
        run_op(2'd3, 16'h8010, 16'd4, 16'hF801, 9 + EXTRA_CYC, "bsra");
        run_op(2'd2, 16'h8010, 16'd4, 16'h0801, 9 + EXTRA_CYC, "bsr");
        run_op(2'd1, 16'h1234, 16'hFFF0, 16'h1234, 1 + EXTRA_CYC, "bsl_n0");

        // Preset S=1, C=1, Z=0 through the pipeline side of the mux.
        wait_idle();
        @(negedge CLK);
        pipe_op = 5'd30; pipe_b = 16'h0006; pipe_exec = 1'b1;
        @(negedge CLK);
        pipe_op = 5'd0; pipe_b = 16'd0; pipe_exec = 1'b0;
        chk("flag_preset", 32'(alu_flags), 32'h6);
        run_op(2'd1, 16'd1, 16'd15, 16'h8000, 31 + EXTRA_CYC, "bsl_15");
`ifdef ALU_SEQ_FLAG_PRESERVE_EN
        chk("bsl_15_flags", 32'(alu_flags), 32'h6);
`else
        chk("bsl_15_flags", 32'(alu_flags), 32'h4);
`endif

        // Start held high through a MUL with changing operands.
        wait_idle();
        @(negedge CLK);
        op = 2'd0; a = 16'd7; b = 16'h00FF; start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 33 + EXTRA_CYC; k++) begin
            @(negedge CLK);
            if (done) ndone++;
            a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
        end
        chk("held_done_count", 32'(ndone), 32'd1);
        chk("held_result", 32'(result), 32'h06F9);
        op = 2'd1; a = 16'd3; b = 16'd2;
        @(negedge CLK);
        chk("idle_after_done", 32'(busy), 32'd0);
        @(negedge CLK);
        start = 1'b0;
        chk("restart_accepted", 32'(busy), 32'd1);
        wait_done("restart");
        chk("restart_result", 32'(result), 32'd12);

        // Reset in the middle of a MUL.
        wait_idle();
        @(negedge CLK);
        op = 2'd0; a = 16'h1234; b = 16'hFFFF; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        RSTb = 1'b0;
        @(negedge CLK);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_exec", 32'(alu_exec), 32'd0);
        RSTb = 1'b1;
        run_op(2'd1, 16'd1, 16'd1, 16'd2, 3 + EXTRA_CYC, "post_rst_bsl");

        // Random traffic with rare resets; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            start = ($urandom_range(0, 2) == 0);
            op    = 2'($urandom);
            a     = 16'($urandom);
            b     = (op == 2'd0) ? 16'($urandom & ((32'd1 << $urandom_range(0, 16)) - 32'd1))
                                 : 16'($urandom);
            RSTb  = ($urandom_range(0, 399) != 0);
        end
        @(negedge CLK);
        start = 1'b0;
        RSTb  = 1'b1;
        wait_idle();
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
